// File: rtl/uart_rx.sv
// UART receiver: 8N1, 16x oversampled, mid-bit sampling.
// Free-running tick divider; break/low line never retriggers.
module uart_rx #(
  parameter int clk_freq  = 125000000,
  parameter int baud_rate = 62500,
  parameter int os_rate   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_dat,
  output logic       rx_done,
  output logic       frame_err,
  output logic       busy
);

  localparam int DIV = clk_freq / (baud_rate * os_rate);
  localparam logic [15:0] DIV_LAST = 16'(DIV - 1);
  localparam logic [3:0]  MID  = 4'(os_rate / 2 - 1);
  localparam logic [3:0]  LAST = 4'(os_rate - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t      state;
  logic [1:0]  sync;
  logic        rx_s;
  logic [15:0] div_cnt;
  logic        tick;
  logic [3:0]  tick_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        armed;

  assign rx_s = sync[1];
  assign tick = (div_cnt == DIV_LAST);
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], rx};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

  // armed drops on a framing error so a held-low break needs a high first
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      rx_dat    <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      armed     <= 1'b0;
    end else begin
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rx_s) begin
            armed <= 1'b1;
          end else if (armed) begin
            state    <= START;
            tick_cnt <= '0;
            bit_cnt  <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (tick_cnt == MID) begin
              tick_cnt <= '0;
              state    <= rx_s ? IDLE : DATA;
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (tick_cnt == LAST) begin
              tick_cnt <= '0;
              shreg    <= {rx_s, shreg[7:1]};
              if (bit_cnt == 3'd7) begin
                state <= STOP;
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (tick_cnt == LAST) begin
              tick_cnt <= '0;
              state    <= IDLE;
              if (rx_s) begin
                rx_dat  <= shreg;
                rx_done <= 1'b1;
              end else begin
                frame_err <= 1'b1;
                armed     <= 1'b0;
              end
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: scoreboarded frames, glitch, break, reset, baud skew.
// Divider scaled to 8 clk/tick (128 clk/bit) to keep the run short.
module tb_uart_rx;

  localparam int BL = 128;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] rx_dat;
  logic       rx_done;
  logic       frame_err;
  logic       busy;

  int errors;
  int checks;
  int n_done;
  int n_ferr;
  int cyc;
  int start_cyc;
  int done_cyc;
  logic [7:0] q[$];

  uart_rx #(
    .clk_freq (8000000),
    .baud_rate(62500),
    .os_rate  (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rx_dat   (rx_dat),
    .rx_done  (rx_done),
    .frame_err(frame_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    logic [7:0] e;
    n_done   = 0;
    n_ferr   = 0;
    done_cyc = 0;
    forever begin
      @(negedge clk);
      if (rx_done || frame_err)
        chk("excl", {31'b0, rx_done & frame_err}, 0);
      if (rx_done) begin
        n_done++;
        done_cyc = cyc;
        chk("q_nonempty", {31'b0, q.size() != 0}, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("rx_dat", {24'b0, rx_dat}, {24'b0, e});
        end
      end
      if (frame_err) n_ferr++;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic stop,
                      input int bl);
    rx = 1'b0;
    start_cyc = cyc;
    if (stop) q.push_back(b);
    wait_clk(bl);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clk(bl);
    end
    rx = stop;
    wait_clk(bl);
  endtask

  initial begin
    int d, f, lat;
    errors = 0;
    checks = 0;
    rst = 1'b0;
    rx  = 1'b1;
    @(negedge clk);
    wait_clk(3);
    chk("rst_dat", {24'b0, rx_dat}, 0);
    chk("rst_done", {31'b0, rx_done}, 0);
    chk("rst_ferr", {31'b0, frame_err}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    rst = 1'b1;
    wait_clk(2 * BL);

    d = n_done; f = n_ferr;
    send(8'hA5, 1'b1, BL);
    wait_clk(BL);
    lat = done_cyc - start_cyc;
    chk("a5_cnt", n_done - d, 1);
    chk("a5_dat", {24'b0, rx_dat}, 8'hA5);
    chk("a5_ferr", n_ferr - f, 0);
    chk("a5_busy", {31'b0, busy}, 0);
    chk("a5_lat", {31'b0, lat >= 1190 && lat <= 1240}, 1);

    d = n_done;
    send(8'h00, 1'b1, BL);
    send(8'hFF, 1'b1, BL);
    wait_clk(2 * BL);
    chk("b2b_cnt", n_done - d, 2);
    chk("b2b_dat", {24'b0, rx_dat}, 8'hFF);

    d = n_done; f = n_ferr;
    rx = 1'b0;
    wait_clk(BL / 4);
    rx = 1'b1;
    wait_clk(2 * BL);
    chk("gl_done", n_done - d, 0);
    chk("gl_ferr", n_ferr - f, 0);
    chk("gl_busy", {31'b0, busy}, 0);
    chk("gl_dat", {24'b0, rx_dat}, 8'hFF);

    d = n_done; f = n_ferr;
    send(8'h3C, 1'b0, BL);
    wait_clk(20 * BL);
    chk("brk_busy", {31'b0, busy}, 0);
    rx = 1'b1;
    wait_clk(2 * BL);
    chk("fe_cnt", n_ferr - f, 1);
    chk("fe_done", n_done - d, 0);
    chk("fe_dat", {24'b0, rx_dat}, 8'hFF);
    send(8'h5A, 1'b1, BL);
    wait_clk(BL);
    chk("5a_cnt", n_done - d, 1);
    chk("5a_dat", {24'b0, rx_dat}, 8'h5A);
    chk("5a_ferr", n_ferr - f, 1);

    d = n_done; f = n_ferr;
    rx = 1'b0;
    wait_clk(BL);
    for (int i = 0; i < 4; i++) begin
      rx = (i == 0);
      wait_clk(BL);
    end
    rst = 1'b0;
    rx  = 1'b1;
    wait_clk(4);
    chk("mr_dat", {24'b0, rx_dat}, 0);
    chk("mr_busy", {31'b0, busy}, 0);
    chk("mr_done", {31'b0, rx_done}, 0);
    chk("mr_ferr", {31'b0, frame_err}, 0);
    wait_clk(BL - 4);
    rst = 1'b1;
    wait_clk(BL);
    chk("mr_np_d", n_done - d, 0);
    chk("mr_np_f", n_ferr - f, 0);
    chk("mr_idle", {31'b0, busy}, 0);
    send(8'h81, 1'b1, BL);
    wait_clk(BL);
    chk("81_cnt", n_done - d, 1);
    chk("81_dat", {24'b0, rx_dat}, 8'h81);

    d = n_done; f = n_ferr;
    for (int i = 0; i < 4; i++) send(8'h55, 1'b1, 132);
    for (int i = 0; i < 4; i++) send(8'h55, 1'b1, 124);
    wait_clk(2 * BL);
    chk("skew_cnt", n_done - d, 8);
    chk("skew_ferr", n_ferr - f, 0);
    chk("skew_q", q.size(), 0);
    chk("skew_busy", {31'b0, busy}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
